// File: rtl/tictac_move_driver.sv
// Automatic tic-tac-toe move issuer: steers the game cursor to a target cell, presses play, confirms placement.
// Latency: 6 cycles from accept to done with zero cursor moves, +4 per move (PULSE_LEN=1, GAP=2).
// Backpressure: move_ready is high only while idle; a command is taken on move_valid && move_ready.
module tictac_move_driver #(
  parameter int PULSE_LEN = 1,
  parameter int GAP       = 2,
  parameter int MAX_MOVES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_valid,
  output logic       move_ready,
  input  logic [3:0] move_target,
  input  logic [3:0] cursor,
  input  logic [8:0] board_x,
  input  logic [8:0] board_o,
  output logic       button_left,
  output logic       button_right,
  output logic       button_up,
  output logic       button_down,
  output logic       button_play,
  output logic       done,
  output logic       error
);

  localparam int TMAX = (PULSE_LEN > GAP) ? PULSE_LEN : GAP;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam int CW   = (MAX_MOVES > 0) ? $clog2(MAX_MOVES + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_DECIDE, S_PRESS, S_GAP, S_PLAY, S_PGAP, S_VERIFY, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {D_LEFT, D_RIGHT, D_UP, D_DOWN} dir_e;

  // Column / row of a grid index via lookup; off-grid indices never reach here.
  function automatic logic [1:0] col_of(input logic [3:0] idx);
    case (idx)
      4'd1, 4'd4, 4'd7: col_of = 2'd1;
      4'd2, 4'd5, 4'd8: col_of = 2'd2;
      default:          col_of = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] row_of(input logic [3:0] idx);
    case (idx)
      4'd3, 4'd4, 4'd5: row_of = 2'd1;
      4'd6, 4'd7, 4'd8: row_of = 2'd2;
      default:          row_of = 2'd0;
    endcase
  endfunction

  state_e          state_q, state_d;
  dir_e            dir_q, dir_d;
  logic [3:0]      tgt_q, tgt_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [4:0]      btn_q, btn_d;   // {left, right, up, down, play}
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rdy_q, rdy_d;
  logic [8:0]      occ;

  assign occ = board_x | board_o;

  // Next-state, command latch, press timing and next registered outputs.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (move_valid) begin
          tgt_d = move_target;
          cnt_d = '0;
          if (move_target > 4'd8)    state_d = S_ERR;
          else if (occ[move_target]) state_d = S_ERR;
          else                       state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (cursor > 4'd8) begin
          state_d = S_ERR;
        end else if (cursor == tgt_q) begin
          state_d = S_PLAY;
          tmr_d   = TW'(PULSE_LEN - 1);
        end else if (cnt_q == CW'(MAX_MOVES)) begin
          state_d = S_ERR;
        end else begin
          state_d = S_PRESS;
          tmr_d   = TW'(PULSE_LEN - 1);
          cnt_d   = cnt_q + CW'(1);
          if (col_of(tgt_q) > col_of(cursor))      dir_d = D_RIGHT;
          else if (col_of(tgt_q) < col_of(cursor)) dir_d = D_LEFT;
          else if (row_of(tgt_q) > row_of(cursor)) dir_d = D_DOWN;
          else                                     dir_d = D_UP;
        end
      end
      S_PRESS, S_PLAY: begin
        if (tmr_q == '0) begin
          state_d = (state_q == S_PRESS) ? S_GAP : S_PGAP;
          tmr_d   = TW'(GAP - 1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_GAP, S_PGAP: begin
        if (tmr_q == '0) state_d = (state_q == S_GAP) ? S_DECIDE : S_VERIFY;
        else             tmr_d   = tmr_q - TW'(1);
      end
      S_VERIFY: state_d = occ[tgt_q] ? S_DONE : S_ERR;
      S_DONE:   state_d = S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they can be registered.
    btn_d = '0;
    if (state_d == S_PRESS) begin
      unique case (dir_d)
        D_LEFT:  btn_d[4] = 1'b1;
        D_RIGHT: btn_d[3] = 1'b1;
        D_UP:    btn_d[2] = 1'b1;
        D_DOWN:  btn_d[1] = 1'b1;
        default: btn_d    = '0;
      endcase
    end
    if (state_d == S_PLAY) btn_d[0] = 1'b1;
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    rdy_d  = (state_d == S_IDLE);
  end

  // State and output registers; reset drops every press immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      dir_q   <= D_LEFT;
      tgt_q   <= '0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      btn_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      btn_q   <= btn_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign move_ready   = rdy_q;
  assign button_left  = btn_q[4];
  assign button_right = btn_q[3];
  assign button_up    = btn_q[2];
  assign button_down  = btn_q[1];
  assign button_play  = btn_q[0];
  assign done         = done_q;
  assign error        = err_q;

endmodule

// File: tb/tb_tictac_move_driver.sv
// Bench for tictac_move_driver: a small game model reacts to button presses while a trace model predicts every output cycle.
// Latency: checks each cycle from accept through the return of move_ready.
// Backpressure: commands are offered only when the previous one has finished.
module tb_tictac_move_driver;

  localparam int P = 1;
  localparam int G = 2;
  localparam int M = 4;

  // Output vector bits: {ready, left, right, up, down, play, done, error}
  localparam logic [7:0] RDY   = 8'h80;
  localparam logic [7:0] LEFT  = 8'h40;
  localparam logic [7:0] RIGHT = 8'h20;
  localparam logic [7:0] UP    = 8'h10;
  localparam logic [7:0] DOWN  = 8'h08;
  localparam logic [7:0] PLAY  = 8'h04;
  localparam logic [7:0] DONEB = 8'h02;
  localparam logic [7:0] ERRB  = 8'h01;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       move_valid = 1'b0;
  logic       move_ready;
  logic [3:0] move_target = '0;
  logic [3:0] cursor = '0;
  logic [8:0] board_x = '0;
  logic [8:0] board_o = '0;
  logic       button_left, button_right, button_up, button_down, button_play;
  logic       done, error;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  tictac_move_driver #(.PULSE_LEN(P), .GAP(G), .MAX_MOVES(M)) dut (
    .clk(clk), .rst(rst),
    .move_valid(move_valid), .move_ready(move_ready), .move_target(move_target),
    .cursor(cursor), .board_x(board_x), .board_o(board_o),
    .button_left(button_left), .button_right(button_right),
    .button_up(button_up), .button_down(button_down), .button_play(button_play),
    .done(done), .error(error)
  );

  function automatic logic [7:0] outv();
    return {move_ready, button_left, button_right, button_up, button_down,
            button_play, done, error};
  endfunction

  // Predicts the per-cycle output trace (cycle 1 after accept onward) from the game rules.
  task automatic build_exp(input int c, input int t, input logic [8:0] occ,
                           input bit stuck, input bit ignore);
    int cur;
    int moves;
    logic [7:0] mv;
    exp_q.delete();
    cur   = c;
    moves = 0;
    if (t > 8) begin
      exp_q.push_back(ERRB); exp_q.push_back(RDY); return;
    end
    if (occ[t]) begin
      exp_q.push_back(ERRB); exp_q.push_back(RDY); return;
    end
    forever begin
      exp_q.push_back(8'h00);                      // decide
      if (cur == t) begin
        repeat (P) exp_q.push_back(PLAY);
        repeat (G) exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);                    // verify
        exp_q.push_back(ignore ? ERRB : DONEB);
        exp_q.push_back(RDY);
        return;
      end
      if (moves == M) begin
        exp_q.push_back(ERRB); exp_q.push_back(RDY); return;
      end
      if (t % 3 > cur % 3)      mv = RIGHT;
      else if (t % 3 < cur % 3) mv = LEFT;
      else if (t / 3 > cur / 3) mv = DOWN;
      else                      mv = UP;
      repeat (P) exp_q.push_back(mv);
      repeat (G) exp_q.push_back(8'h00);
      moves++;
      if (!stuck) begin
        if (mv == RIGHT)     cur = cur + 1;
        else if (mv == LEFT) cur = cur - 1;
        else if (mv == DOWN) cur = cur + 3;
        else                 cur = cur - 3;
      end
    end
  endtask

  // Issues one command (entered just after a falling edge) and checks every cycle against the trace.
  task automatic run_cmd(input string name, input int c, input int t,
                         input logic [8:0] bx, input logic [8:0] bo,
                         input bit stuck, input bit ignore);
    logic [7:0] got;
    int k;
    build_exp(c, t, bx | bo, stuck, ignore);
    n_vec++;
    if (outv() !== RDY) begin
      n_err++;
      $display("FAIL %s idle: got %b want %b", name, outv(), RDY);
    end
    cursor      = 4'(c);
    board_x     = bx;
    board_o     = bo;
    move_target = 4'(t);
    move_valid  = 1'b1;
    @(posedge clk);
    k = 0;
    foreach (exp_q[i]) begin
      @(negedge clk);
      k++;
      got = outv();
      n_vec++;
      if (got !== exp_q[i]) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b want %b", name, k, got, exp_q[i]);
      end
      move_valid  = 1'b0;
      move_target = 4'($urandom_range(0, 15));
      // Game model reacts to presses.
      if (!stuck) begin
        if (button_right && (cursor % 3) < 2) cursor = cursor + 4'd1;
        if (button_left  && (cursor % 3) > 0) cursor = cursor - 4'd1;
        if (button_down  && cursor < 4'd6)    cursor = cursor + 4'd3;
        if (button_up    && cursor > 4'd2)    cursor = cursor - 4'd3;
      end
      if (button_play && !ignore && cursor <= 4'd8 && !board_x[cursor] && !board_o[cursor])
        board_x[cursor] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #7;
    n_vec++;
    if (outv() !== RDY) begin
      n_err++;
      $display("FAIL reset_state: got %b want %b", outv(), RDY);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plan();
    run_cmd("right_one",    0, 1, 9'h000, 9'h000, 1'b0, 1'b0);
    run_cmd("down_two",     1, 7, 9'h001, 9'h000, 1'b0, 1'b0);
    run_cmd("corner",       8, 0, 9'h000, 9'h000, 1'b0, 1'b0);
    run_cmd("occupied",     0, 4, 9'h000, 9'h010, 1'b0, 1'b0);
    run_cmd("off_grid",     0, 9, 9'h000, 9'h000, 1'b0, 1'b0);
    run_cmd("stuck",        0, 2, 9'h000, 9'h000, 1'b1, 1'b0);
    run_cmd("play_ignored", 3, 5, 9'h000, 9'h000, 1'b0, 1'b1);
    run_cmd("already_there", 4, 4, 9'h101, 9'h000, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int c, t;
    logic [8:0] occ, split;
    for (int n = 0; n < 30; n++) begin
      c     = $urandom_range(0, 8);
      t     = ($urandom_range(0, 9) == 0) ? 9 : $urandom_range(0, 8);
      occ   = 9'($urandom) & 9'($urandom) & 9'($urandom);
      split = 9'($urandom);
      run_cmd("random", c, t, occ & split, occ & ~split,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end
  endtask

  task automatic test_back_to_back();
    run_cmd("b2b_a", 2, 6, 9'h000, 9'h000, 1'b0, 1'b0);
    run_cmd("b2b_b", 6, 2, 9'h000, 9'h000, 1'b0, 1'b0);
    run_cmd("b2b_c", 5, 5, 9'h000, 9'h020, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midpress();
    bit seen;
    seen        = 1'b0;
    cursor      = 4'd0;
    board_x     = '0;
    board_o     = '0;
    move_target = 4'd6;
    move_valid  = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      move_valid = 1'b0;
      if (button_down) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL midpress_seen: got button_down 0 want 1");
    end
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    if (outv() !== RDY) begin
      n_err++;
      $display("FAIL midpress_drop: got %b want %b", outv(), RDY);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_vec++;
      if (outv() !== RDY) begin
        n_err++;
        $display("FAIL post_reset cycle %0d: got %b want %b", k, outv(), RDY);
      end
    end
    run_cmd("after_reset", 0, 3, 9'h000, 9'h000, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_plan();
    test_random();
    test_back_to_back();
    test_reset_midpress();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
